// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial transmitter: accepts an N-bit word via valid/ready and shifts it out LSB first, one bit per tick.
// Optional even-parity trailer bit is enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx_shifter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         tick,
    output logic         out_bit,
    output logic         out_valid,
    output logic         out_last,
    output logic         busy
);

`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif
    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t         state_q;
    logic [N-1:1]   pend_q;
    logic [CW-1:0]  cnt_q;
    logic           out_bit_q;
    logic           out_valid_q;
    logic           out_last_q;

    // Bit 0 of the word lives in out_bit_q, so only the not-yet-presented bits are held here.
    logic [N-1:0]   pend_ext;
    logic [CW-1:0]  cnt_inc;
    logic           next_bit;

    assign pend_ext = {1'b0, pend_q};
    assign cnt_inc  = cnt_q + CW'(1);

`ifdef SERIAL_TX_PARITY_EN
    logic parity_q;
    assign next_bit = (cnt_inc == CW'(N)) ? parity_q : pend_ext[0];
`else
    assign next_bit = pend_ext[0];
`endif

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            cnt_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else if (state_q == ST_IDLE) begin
            if (in_valid && in_ready) begin
                state_q     <= ST_SHIFT;
                pend_q      <= in_data[N-1:1];
                cnt_q       <= '0;
                out_bit_q   <= in_data[0];
                out_valid_q <= 1'b1;
                out_last_q  <= (LAST_IDX == '0);
`ifdef SERIAL_TX_PARITY_EN
                parity_q    <= ^in_data;
`endif
            end
        end else if (tick) begin
            pend_q <= pend_ext[N-1:1];
            cnt_q  <= cnt_inc;
            if (cnt_q == LAST_IDX) begin
                state_q     <= ST_IDLE;
                out_bit_q   <= 1'b0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                out_bit_q  <= next_bit;
                out_last_q <= (cnt_inc == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Scoreboard bench for serial_tx_shifter: stimulus pushes accepted words, a monitor deserializes and compares.
// Honors SERIAL_TX_PARITY_EN the same way as the design.
module tb_serial_tx_shifter;
    localparam int N = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         tick = 1'b0;
    logic         in_ready;
    logic         out_bit;
    logic         out_valid;
    logic         out_last;
    logic         busy;

    int checks = 0;
    int passed = 0;
    int tick_mode = 0;   // 0 every cycle, 1 every 3rd cycle, 2 random

    logic [N-1:0]     exp_q[$];
    logic             mon_valid = 1'b0;
    int               mon_idx = 0;
    logic [FRAME-1:0] mon_des = '0;
    logic [N-1:0]     mon_word;

    serial_tx_shifter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tick      (tick),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference frame: data bits LSB first, then the even-parity bit when enabled.
    function automatic logic frame_bit(input logic [N-1:0] w, input int i);
        if (i < N) return w[i];
        return ^w;
    endfunction

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (tick_mode)
                0:       tick = 1'b1;
                1:       tick = (ph % 3 == 0);
                default: tick = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("out_valid", 32'(out_valid), 32'(mon_valid));
            check("busy", 32'(busy), 32'(mon_valid));
            check("in_ready", 32'(in_ready), 32'(!mon_valid && !rst));
            if (!mon_valid) begin
                check("idle_out_bit", 32'(out_bit), 32'd0);
                check("idle_out_last", 32'(out_last), 32'd0);
            end
            if (rst) begin
                mon_valid = 1'b0;
                mon_idx   = 0;
                mon_des   = '0;
                exp_q.delete();
            end else if (mon_valid && exp_q.size() > 0) begin
                mon_word = exp_q[0];
                check("out_bit", 32'(out_bit), 32'(frame_bit(mon_word, mon_idx)));
                check("out_last", 32'(out_last), 32'(mon_idx == FRAME - 1));
                if (tick) begin
                    mon_des = {out_bit, mon_des[FRAME-1:1]};
                    if (mon_idx == FRAME - 1) begin
                        check("frame_word", 32'(mon_des[N-1:0]), 32'(mon_word));
`ifdef SERIAL_TX_PARITY_EN
                        check("frame_parity", 32'(^mon_des), 32'd0);
`endif
                        $display("frame word=%0h received=%0h", mon_word, mon_des[N-1:0]);
                        void'(exp_q.pop_front());
                        mon_valid = 1'b0;
                        mon_idx   = 0;
                    end else begin
                        mon_idx++;
                    end
                end
            end else if (!mon_valid && exp_q.size() > 0) begin
                mon_valid = 1'b1;
                mon_idx   = 0;
            end
        end
    end

    task automatic send(input logic [N-1:0] w, input bit keep_valid);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                checks++;
                $display("FAIL accept_timeout: in_ready=%0b required 1 word=%0h", in_ready, w);
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() > 0 || mon_valid) begin
            @(negedge clk);
            #2;
            t++;
            if (t > 500) begin
                checks++;
                $display("FAIL frame_timeout: pending=%0d required 0", exp_q.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] w;
        bit kv;
        in_valid = 1'b1;
        in_data  = 4'hA;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        tick_mode = 0;
        send(4'b1011, 1'b0);
        wait_done();

        tick_mode = 1;
        send(4'b0110, 1'b0);
        wait_done();

        tick_mode = 0;
        send(4'hA, 1'b1);
        send(4'h5, 1'b0);
        wait_done();

        send(4'hF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        pulse_reset(1);
        send(4'h3, 1'b0);
        wait_done();

        tick_mode = 2;
        for (int i = 0; i < 60; i++) begin
            w  = N'($urandom);
            kv = 1'($urandom_range(0, 1));
            send(w, kv);
            if (kv) send(N'($urandom), 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
                pulse_reset(1);
            end
            wait_done();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
